// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage.
package riscv_pkg;
   localparam int XLEN             = 64;
   localparam int ILEN             = 32;
   localparam int FETCH_ADDR_ALIGN = 2;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] addr;
   } imem_req_t;

   typedef struct packed {
      logic [ILEN-1:0] data;
      logic            err;
   } imem_rsp_t;
endpackage

// File: rtl/riscv_if_fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer and the request-PC queue.
module riscv_if_fetch_fifo
   import riscv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO may still accept a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wptr] <= wdata;
   end

   no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
      !(push && full && !pop));
endmodule

// File: rtl/riscv_if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers responses for ID and drops stale responses after a redirect.
module riscv_if_fetch_unit
   import riscv_pkg::*;
#(
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    ADDR_WIDTH  = 64,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    FIFO_DEPTH  = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic                   o_imem_req_valid,
   input  logic                   i_imem_req_ready,
   output logic [ADDR_WIDTH-1:0]  o_imem_req_addr,
   input  logic                   i_imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
   input  logic                   i_imem_rsp_err,
   input  logic                   i_redirect,
   input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
   output logic                   o_instr_valid,
   input  logic                   i_id_ready,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [ADDR_WIDTH-1:0]  o_instr_pc,
   output logic                   o_fetch_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = INSTR_WIDTH + 1 + ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0]  pc;
   logic [CW-1:0]          drop;
   logic [CW:0]            outstanding;
   logic [CW:0]            outstanding_nxt;
   logic [CW:0]            credit_used;
   logic                   accept;
   logic                   rsp_keep;
   logic                   pop;

   logic [ADDR_WIDTH-1:0]  pq_head;
   logic [CW-1:0]          pq_count;
   logic                   pq_full;
   logic                   pq_empty;

   logic [EW-1:0]          ib_head;
   logic [CW-1:0]          ib_count;
   logic                   ib_full;
   logic                   ib_empty;

   // Every in-flight request is either tracked in the PC queue or pending drop.
   assign outstanding     = {1'b0, pq_count} + {1'b0, drop};
   assign credit_used     = outstanding + {1'b0, ib_count};
   assign outstanding_nxt = outstanding + (CW+1)'(accept) - (CW+1)'(i_imem_rsp_valid);

   // full terms are implied by the credit check; kept so neither queue can be overrun
   assign o_imem_req_valid = !i_rst && !i_redirect && !pq_full && !ib_full &&
                             (credit_used < (CW+1)'(FIFO_DEPTH));
   assign o_imem_req_addr  = pc;
   assign accept           = o_imem_req_valid && i_imem_req_ready;
   assign rsp_keep         = i_imem_rsp_valid && (drop == '0) && !pq_empty;

   assign o_instr_valid = !ib_empty && !i_redirect && !i_rst;
   assign pop           = o_instr_valid && i_id_ready;

   always_comb begin
      o_instr     = INSTR_WIDTH'(NOP_INSTR);
      o_instr_pc  = '0;
      o_fetch_err = 1'b0;
      if (!ib_empty && !i_rst) begin
         o_instr     = ib_head[ADDR_WIDTH+1 +: INSTR_WIDTH];
         o_fetch_err = ib_head[ADDR_WIDTH];
         o_instr_pc  = ib_head[ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc   <= RESET_PC;
         drop <= '0;
      end else if (i_redirect) begin
         pc   <= {i_redirect_pc[ADDR_WIDTH-1:FETCH_ADDR_ALIGN], {FETCH_ADDR_ALIGN{1'b0}}};
         drop <= outstanding_nxt[CW-1:0];
      end else begin
         if (accept) pc <= pc + ADDR_WIDTH'(4);
         if (i_imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
   end

   riscv_if_fetch_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_pc_queue (
      .clk   (i_clk),
      .rst   (i_rst),
      .flush (i_redirect),
      .push  (accept),
      .pop   (rsp_keep),
      .wdata (pc),
      .rdata (pq_head),
      .count (pq_count),
      .full  (pq_full),
      .empty (pq_empty)
   );

   riscv_if_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_buf (
      .clk   (i_clk),
      .rst   (i_rst),
      .flush (i_redirect),
      .push  (rsp_keep),
      .pop   (pop),
      .wdata ({i_imem_rsp_data, i_imem_rsp_err, pq_head}),
      .rdata (ib_head),
      .count (ib_count),
      .full  (ib_full),
      .empty (ib_empty)
   );
endmodule

// File: tb/tb_riscv_if_fetch_unit.sv
// Bench for riscv_if_fetch_unit: randomized memory/ID/redirect traffic checked against a queue model.
module tb_riscv_if_fetch_unit;
   localparam int          DEPTH    = 2;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        redir;
   logic [63:0] redir_pc;
   logic        idr;
   logic        req_valid;
   logic [63:0] req_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        fetch_err;

   riscv_if_fetch_unit dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (rdy),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .i_imem_rsp_err   (rsp_err),
      .i_redirect       (redir),
      .i_redirect_pc    (redir_pc),
      .o_instr_valid    (instr_valid),
      .i_id_ready       (idr),
      .o_instr          (instr),
      .o_instr_pc       (instr_pc),
      .o_fetch_err      (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [63:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [63:0] pc; logic [31:0] data; logic err; } ent_t;

   pend_t       pend[$];
   ent_t        buff[$];
   logic [63:0] model_pc, next_id_pc;
   int          cyc, last_due, lat_min, lat_max, n_acc;
   logic [63:0] err_addr;
   bit          err_rand;
   bit          last_iv, last_req;
   logic [63:0] last_addr, last_ipc, err_seen_pc, prev_acc_addr, wrap_addr;
   logic [31:0] last_instr;
   int          n_chk, n_err;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F01;
   endfunction

   function automatic logic err_of(input logic [63:0] a);
      return (a == err_addr) || (err_rand && a[5:2] == 4'hB);
   endfunction

   task automatic cycle();
      bit    rv, acc, con, exp_req, exp_iv;
      int    due;
      pend_t p;
      ent_t  e;
      rv        = !rst && pend.size() > 0 && pend[0].due <= cyc;
      rsp_valid = rv;
      rsp_data  = rv ? instr_of(pend[0].addr) : 32'h0;
      rsp_err   = rv ? err_of(pend[0].addr) : 1'b0;
      @(negedge clk);
      exp_req = !rst && !redir && (pend.size() + buff.size() < DEPTH);
      exp_iv  = !rst && !redir && buff.size() > 0;
      chk("req_valid", req_valid, exp_req);
      if (exp_req) chk("req_addr", req_addr, model_pc);
      chk("instr_valid", instr_valid, exp_iv);
      if (exp_iv) begin
         chk("instr_pc", instr_pc, buff[0].pc);
         chk("instr", instr, buff[0].data);
         chk("fetch_err", fetch_err, buff[0].err);
      end else if (rst || buff.size() == 0) begin
         chk("idle_instr", instr, NOP);
         chk("idle_pc", instr_pc, 64'h0);
         chk("idle_err", fetch_err, 1'b0);
      end
      last_iv    = instr_valid;
      last_req   = req_valid;
      last_addr  = req_addr;
      last_ipc   = instr_pc;
      last_instr = instr;
      acc = req_valid && rdy;
      con = instr_valid && idr;
      if (con) begin
         chk("id_order", instr_pc, next_id_pc);
         if (fetch_err) err_seen_pc = instr_pc;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         pend.delete();
         buff.delete();
         model_pc   = RESET_PC;
         next_id_pc = RESET_PC;
         last_due   = cyc;
      end else begin
         if (con && buff.size() > 0) begin
            void'(buff.pop_front());
            next_id_pc = next_id_pc + 64'd4;
         end
         if (rv) begin
            p = pend.pop_front();
            if (!p.stale) begin
               e.pc   = p.addr;
               e.data = instr_of(p.addr);
               e.err  = err_of(p.addr);
               buff.push_back(e);
            end
         end
         if (redir) begin
            buff.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            model_pc   = {redir_pc[63:2], 2'b00};
            next_id_pc = model_pc;
         end else if (acc) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.addr  = model_pc;
            p.due   = due;
            p.stale = 1'b0;
            pend.push_back(p);
            if (prev_acc_addr == 64'hFFFF_FFFF_FFFF_FFFC) wrap_addr = model_pc;
            prev_acc_addr = model_pc;
            model_pc = model_pc + 64'd4;
            n_acc++;
         end
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst   = 1'b1;
      redir = 1'b0;
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   initial begin
      int  first, acc0;
      bit  found;
      rst = 1'b1; rdy = 1'b0; idr = 1'b0; redir = 1'b0; redir_pc = '0;
      rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      cyc = 0; last_due = 0; n_acc = 0; n_chk = 0; n_err = 0;
      lat_min = 1; lat_max = 1; err_addr = 64'h8; err_rand = 1'b0;
      model_pc = RESET_PC; next_id_pc = RESET_PC;
      err_seen_pc = '1; prev_acc_addr = '0; wrap_addr = '1;

      // streaming from reset, 1-cycle memory, error on pc 8
      do_reset(2);
      rdy = 1'b1; idr = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (last_iv) begin first = i; break; end
      end
      chk("first_valid_cycle", first, 3);
      repeat (30) cycle();
      chk("err_pc", err_seen_pc, 64'h8);
      err_addr = '1;

      // ID stall: credits exhausted, head frozen at pc 0
      do_reset(1);
      idr  = 1'b0;
      acc0 = n_acc;
      repeat (10) cycle();
      chk("stall_reqs", n_acc - acc0, DEPTH);
      chk("stall_head_valid", last_iv, 1'b1);
      chk("stall_head_pc", last_ipc, 64'h0);
      chk("stall_req_off", last_req, 1'b0);
      idr = 1'b1;
      repeat (20) cycle();

      // redirect with two fetches in flight
      do_reset(1);
      lat_min = 3; lat_max = 3;
      repeat (2) cycle();
      redir = 1'b1; redir_pc = 64'h100;
      cycle();
      redir = 1'b0;
      cycle();
      chk("redir_addr", last_addr, 64'h100);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (last_iv) begin found = 1'b1; break; end
         cycle();
      end
      chk("redir_seen", found, 1'b1);
      if (found) chk("redir_first_pc", last_ipc, 64'h100);

      // unaligned redirect target
      lat_min = 1; lat_max = 1;
      redir = 1'b1; redir_pc = 64'h103;
      cycle();
      redir = 1'b0;
      cycle();
      chk("align_addr", last_addr, 64'h100);
      repeat (10) cycle();

      // PC wrap past the top of the address space
      redir = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      cycle();
      redir = 1'b0;
      repeat (12) cycle();
      chk("wrap_addr", wrap_addr, 64'h0);

      // reset and redirect together
      rst = 1'b1; redir = 1'b1; redir_pc = 64'h500;
      cycle();
      chk("rst_req_valid", last_req, 1'b0);
      chk("rst_instr_valid", last_iv, 1'b0);
      chk("rst_instr", last_instr, NOP);
      rst = 1'b0; redir = 1'b0;
      cycle();
      chk("post_rst_addr", last_addr, RESET_PC);

      // randomized traffic
      lat_min = 1; lat_max = 4; err_rand = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         idr   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0)
            redir_pc = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom)};
         else
            redir_pc = {48'h0, 16'($urandom)};
         cycle();
      end
      rst = 1'b0; redir = 1'b0; idr = 1'b1; rdy = 1'b1;
      repeat (20) cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
